// File: rtl/fp_int_acc_if.sv
// rtl/fp_int_acc_if.sv - product input and result output bundle for fp_int_acc
interface fp_int_acc_if #(
    parameter int ACC_WIDTH = 32,
    parameter int CNT_WIDTH = 8
);
    logic                 clear;
    logic                 sign_in;
    logic [4:0]           exp_in;
    logic [13:0]          mantissa_in;
    logic                 start_acc;
    logic                 last_in;
    logic [ACC_WIDTH-1:0] acc_out;
    logic                 acc_valid;
    logic                 acc_ready;
    logic [CNT_WIDTH-1:0] prod_cnt;
    logic                 overrun;
    logic                 sat_flag;

    // Producer/consumer side: drives products, clear and acc_ready
    modport master (
        output clear, sign_in, exp_in, mantissa_in, start_acc, last_in, acc_ready,
        input  acc_out, acc_valid, prod_cnt, overrun, sat_flag
    );

    // Accumulator side
    modport slave (
        input  clear, sign_in, exp_in, mantissa_in, start_acc, last_in, acc_ready,
        output acc_out, acc_valid, prod_cnt, overrun, sat_flag
    );
endinterface

// File: rtl/fp_int_acc.sv
// rtl/fp_int_acc.sv - fixed-point dot-product accumulator behind fp_int_mul; FP_INT_ACC_SAT_EN enables saturating sum
module fp_int_acc #(
    parameter int ACC_WIDTH = 32,
    parameter int FRAC_BITS = 8,
    parameter int CNT_WIDTH = 8
) (
    input logic         clk,
    input logic         rst,
    fp_int_acc_if.slave bus
);
    // Product value is mantissa * 2^(exp-25); grid LSB is 2^-FRAC_BITS
    localparam int SHIFT = 25 - FRAC_BITS;
    localparam int WIDE  = (ACC_WIDTH > 45) ? ACC_WIDTH : 45;

    typedef enum logic {S_IDLE, S_ACCUM} state_t;

    // Input capture stage
    logic                 in_valid_q;
    logic                 in_last_q;
    logic                 in_sign_q;
    logic [4:0]           in_exp_q;
    logic [13:0]          in_mant_q;

    // Aligned stage
    logic                 s1_valid_q;
    logic                 s1_last_q;
    logic [ACC_WIDTH-1:0] s1_aligned_q;
    logic [ACC_WIDTH-1:0] aligned_d;

    // Accumulate stage
    state_t               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
    logic                 acc_valid_q, acc_valid_d;
    logic [CNT_WIDTH-1:0] prod_cnt_q, prod_cnt_d;
    logic                 overrun_q, overrun_d;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH-1:0] sum_wrap;
    logic [ACC_WIDTH-1:0] sum;

    logic [WIDE-1:0]      mag_shl;
    logic [WIDE-1:0]      mag_shr;
    logic [ACC_WIDTH-1:0] mag;

`ifdef FP_INT_ACC_SAT_EN
    logic                 sat_q, sat_d;
    logic                 ovf_pos;
    logic                 ovf_neg;
`endif

    // Capture product fields; clear drops anything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            in_valid_q <= 1'b0;
            in_last_q  <= 1'b0;
            in_sign_q  <= 1'b0;
            in_exp_q   <= '0;
            in_mant_q  <= '0;
        end else begin
            in_valid_q <= bus.start_acc && !bus.clear;
            in_last_q  <= bus.last_in;
            in_sign_q  <= bus.sign_in;
            in_exp_q   <= bus.exp_in;
            in_mant_q  <= bus.mantissa_in;
        end
    end

    // Align magnitude onto the grid (truncating), then apply sign so rounding is toward zero
    always_comb begin
        mag_shl   = WIDE'(in_mant_q) << in_exp_q;
        mag_shr   = mag_shl >> SHIFT;
        mag       = mag_shr[ACC_WIDTH-1:0];
        aligned_d = in_sign_q ? (ACC_WIDTH'(0) - mag) : mag;
    end

    // Aligned-term register
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_last_q    <= 1'b0;
            s1_aligned_q <= '0;
        end else begin
            s1_valid_q   <= in_valid_q && !bus.clear;
            s1_last_q    <= in_last_q;
            s1_aligned_q <= aligned_d;
        end
    end

    // Adder: a term arriving in IDLE always starts from zero
    always_comb begin
        acc_base = (state_q == S_ACCUM) ? acc_q : '0;
        sum_wrap = acc_base + s1_aligned_q;
`ifdef FP_INT_ACC_SAT_EN
        ovf_pos = !acc_base[ACC_WIDTH-1] && !s1_aligned_q[ACC_WIDTH-1] &&  sum_wrap[ACC_WIDTH-1];
        ovf_neg =  acc_base[ACC_WIDTH-1] &&  s1_aligned_q[ACC_WIDTH-1] && !sum_wrap[ACC_WIDTH-1];
        if (ovf_pos) begin
            sum = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else if (ovf_neg) begin
            sum = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        end else begin
            sum = sum_wrap;
        end
`else
        sum = sum_wrap;
`endif
    end

    // FSM next state, accumulator commit and result/handshake bookkeeping
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        acc_out_d   = acc_out_q;
        acc_valid_d = acc_valid_q;
        prod_cnt_d  = prod_cnt_q;
        overrun_d   = overrun_q;
`ifdef FP_INT_ACC_SAT_EN
        sat_d       = sat_q;
`endif
        if (acc_valid_q && bus.acc_ready) begin
            acc_valid_d = 1'b0;
        end
        if (bus.clear) begin
            state_d    = S_IDLE;
            acc_d      = '0;
            prod_cnt_d = '0;
            overrun_d  = 1'b0;
`ifdef FP_INT_ACC_SAT_EN
            sat_d      = 1'b0;
`endif
        end else if (s1_valid_q) begin
`ifdef FP_INT_ACC_SAT_EN
            if (ovf_pos || ovf_neg) begin
                sat_d = 1'b1;
            end
`endif
            if (s1_last_q) begin
                acc_out_d   = sum;
                acc_valid_d = 1'b1;
                acc_d       = '0;
                prod_cnt_d  = '0;
                state_d     = S_IDLE;
                if (acc_valid_q && !bus.acc_ready) begin
                    overrun_d = 1'b1;
                end
            end else begin
                acc_d      = sum;
                prod_cnt_d = prod_cnt_q + CNT_WIDTH'(1);
                state_d    = S_ACCUM;
            end
        end
    end

    // Accumulate-stage and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            acc_out_q   <= '0;
            acc_valid_q <= 1'b0;
            prod_cnt_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc_out_q   <= acc_out_d;
            acc_valid_q <= acc_valid_d;
            prod_cnt_q  <= prod_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef FP_INT_ACC_SAT_EN
    // Sticky saturation flag
    always_ff @(posedge clk) begin
        if (rst) begin
            sat_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
        end
    end
    assign bus.sat_flag = sat_q;
`else
    assign bus.sat_flag = 1'b0;
`endif

    assign bus.acc_out   = acc_out_q;
    assign bus.acc_valid = acc_valid_q;
    assign bus.prod_cnt  = prod_cnt_q;
    assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_fp_int_acc.sv
// tb/tb_fp_int_acc.sv - scoreboard bench for fp_int_acc with directed product vectors
module tb_fp_int_acc;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fp_int_acc_if #(.ACC_WIDTH(AW), .CNT_WIDTH(8)) bus ();

    fp_int_acc #(.ACC_WIDTH(AW), .FRAC_BITS(8), .CNT_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [AW-1:0] exp_q[$];

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic put(input int m, input int e, input bit s, input bit l);
        bus.mantissa_in = 14'(m);
        bus.exp_in      = 5'(e);
        bus.sign_in     = s;
        bus.last_in     = l;
        bus.start_acc   = 1'b1;
        @(posedge clk);
        #1;
        bus.start_acc   = 1'b0;
        bus.last_in     = 1'b0;
    endtask

    // Monitor: every accepted result is checked against the next expected value
    always @(negedge clk) begin
        if (!rst && bus.acc_valid && bus.acc_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_result: got 0x%08h expected none", bus.acc_out);
            end else begin
                chk("result", bus.acc_out, exp_q.pop_front());
            end
        end
    end

    logic [63:0] wide;
    logic [AW-1:0] sat_exp;

    initial begin
        rst             = 1'b1;
        bus.clear       = 1'b0;
        bus.sign_in     = 1'b0;
        bus.exp_in      = '0;
        bus.mantissa_in = '0;
        bus.start_acc   = 1'b0;
        bus.last_in     = 1'b0;
        bus.acc_ready   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_acc_out", bus.acc_out, 32'h0);
        chk("rst_acc_valid", 32'(bus.acc_valid), 32'h0);
        chk("rst_prod_cnt", 32'(bus.prod_cnt), 32'h0);
        chk("rst_overrun", 32'(bus.overrun), 32'h0);
        chk("rst_sat_flag", 32'(bus.sat_flag), 32'h0);

        // Unit term with latency: visible only after edge N+2
        exp_q.push_back(32'h0000_0100);
        put(1024, 15, 1'b0, 1'b1);
        chk("lat_after_n", 32'(bus.acc_valid), 32'h0);
        idle(1);
        chk("lat_after_n1", 32'(bus.acc_valid), 32'h0);
        idle(1);
        chk("lat_after_n2", 32'(bus.acc_valid), 32'h1);
        chk("unit_acc_out", bus.acc_out, 32'h0000_0100);
        chk("unit_prod_cnt", 32'(bus.prod_cnt), 32'h0);
        idle(2);

        // Negative single term
        exp_q.push_back(32'hFFFF_FF00);
        put(1024, 15, 1'b1, 1'b1);
        idle(3);

        // Signed sum with a zero-mantissa negative term: 1 - 2 + 1.5 = 0.5
        put(1024, 15, 1'b0, 1'b0);
        put(0, 28, 1'b1, 1'b0);
        put(1024, 16, 1'b1, 1'b0);
        idle(2);
        chk("sum_prod_cnt_mid", 32'(bus.prod_cnt), 32'd3);
        exp_q.push_back(32'h0000_0080);
        put(1536, 15, 1'b0, 1'b1);
        idle(3);
        chk("sum_prod_cnt_end", 32'(bus.prod_cnt), 32'h0);

        // Truncation toward zero and smallest representable step
        exp_q.push_back(32'h0000_0000);
        put(1, 0, 1'b1, 1'b1);
        exp_q.push_back(32'h0000_0001);
        put(1024, 7, 1'b0, 1'b1);
        exp_q.push_back(32'hFFFF_FFFE);
        put(1535, 8, 1'b1, 1'b1);
        exp_q.push_back(32'h0FFF_C000);
        put(16383, 31, 1'b0, 1'b1);
        idle(4);

        // Back-to-back results with consumer ready: no overrun
        exp_q.push_back(32'h0000_0100);
        put(1024, 15, 1'b0, 1'b1);
        exp_q.push_back(32'h0000_0200);
        put(1024, 16, 1'b0, 1'b1);
        idle(4);
        chk("b2b_overrun", 32'(bus.overrun), 32'h0);

        // Back-to-back results with consumer stalled: second overwrites first
        bus.acc_ready = 1'b0;
        put(1024, 15, 1'b0, 1'b1);
        exp_q.push_back(32'h0000_0300);
        put(1536, 16, 1'b0, 1'b1);
        idle(3);
        chk("ovr_overrun", 32'(bus.overrun), 32'h1);
        chk("ovr_acc_valid", 32'(bus.acc_valid), 32'h1);
        chk("ovr_acc_out", bus.acc_out, 32'h0000_0300);
        bus.acc_ready = 1'b1;
        idle(2);
        chk("ovr_drained", 32'(bus.acc_valid), 32'h0);
        bus.clear = 1'b1;
        idle(1);
        bus.clear = 1'b0;
        chk("clear_overrun", 32'(bus.overrun), 32'h0);

        // clear mid-sum with a third term on the clear cycle
        put(1024, 15, 1'b0, 1'b0);
        put(1024, 15, 1'b0, 1'b0);
        bus.clear = 1'b1;
        put(1024, 15, 1'b0, 1'b0);
        bus.clear = 1'b0;
        idle(4);
        chk("clear_prod_cnt", 32'(bus.prod_cnt), 32'h0);
        chk("clear_acc_valid", 32'(bus.acc_valid), 32'h0);
        exp_q.push_back(32'h0000_0100);
        put(1024, 15, 1'b0, 1'b1);
        idle(4);

        // rst mid-sum
        put(1024, 15, 1'b0, 1'b0);
        put(1024, 15, 1'b0, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(2);
        chk("rstmid_prod_cnt", 32'(bus.prod_cnt), 32'h0);
        chk("rstmid_acc_valid", 32'(bus.acc_valid), 32'h0);
        exp_q.push_back(32'h0000_0100);
        put(1024, 15, 1'b0, 1'b1);
        idle(4);

        // Saturation / wrap: 4000 maximal terms, then a zero last term
        wide = 64'd4000 * 64'h0FFF_C000;
`ifdef FP_INT_ACC_SAT_EN
        sat_exp = 32'h7FFF_FFFF;
`else
        sat_exp = wide[AW-1:0];
`endif
        for (int i = 0; i < 4000; i++) begin
            put(16383, 31, 1'b0, 1'b0);
        end
        exp_q.push_back(sat_exp);
        put(0, 0, 1'b0, 1'b1);
        idle(4);
`ifdef FP_INT_ACC_SAT_EN
        chk("sat_flag", 32'(bus.sat_flag), 32'h1);
`else
        chk("sat_flag", 32'(bus.sat_flag), 32'h0);
`endif

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) begin
            idle(1);
        end
        chk("results_outstanding", 32'(exp_q.size()), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fp_int_acc.md
# fp_int_acc

Fixed-point accumulator stage directly downstream of `fp_int_mul`. Consumes each sign/exponent/mantissa product on its `start_acc` pulse, aligns it to a signed fixed-point grid, and sums it into an `ACC_WIDTH` accumulator. A `last_in` marker closes a dot product and presents the sum on a valid/ready output register.

## Interface
- `ACC_WIDTH`, 32: accumulator and result width, two's complement; must be ≥ 21+`FRAC_BITS`.
- `FRAC_BITS`, 8: fractional bits of the accumulator grid.
- `CNT_WIDTH`, 8: width of product counter.
- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `clear` in 1: synchronous flush of pipeline, accumulator, counter and sticky flags; no output produced.
- `sign_in` in 1: product sign from `fp_int_mul` (`sign_out`).
- `exp_in` in 5: biased FP16 exponent (`exp_out`).
- `mantissa_in` in 14: unsigned product magnitude with 10 fractional bits (`mantissa_out`).
- `start_acc` in 1: one-cycle strobe, product inputs valid this cycle.
- `last_in` in 1: qualifies `start_acc`; product is the final term of the current sum.
- `acc_out` out `ACC_WIDTH`: completed sum, Q(`ACC_WIDTH`-`FRAC_BITS`).`FRAC_BITS`.
- `acc_valid` out 1: `acc_out` holds an unconsumed result.
- `acc_ready` in 1: consumer accepts result when high with `acc_valid`.
- `prod_cnt` out `CNT_WIDTH`: products accumulated into the current sum, wraps.
- `overrun` out 1: sticky; a result was overwritten before acceptance.
- `sat_flag` out 1: sticky; saturation occurred (see Configuration).

## Operation
- Value of a product: (−1)^sign × mantissa_in × 2^(exp_in − 25).
- Stage 1 (align): mag = (mantissa_in << exp_in) computed at 45 bits, then >> (25 − `FRAC_BITS`) (truncation); aligned = sign ? −mag : mag, sign-extended to `ACC_WIDTH`. Result truncates toward zero. mantissa_in = 0 yields 0 regardless of sign or exponent.
- Stage 2 (add): sum = acc + aligned.
  - not last: acc ← sum, prod_cnt ← prod_cnt+1.
  - last: acc_out ← sum, acc_valid ← 1, acc ← 0, prod_cnt ← 0.
- FSM `IDLE` (acc = 0, no term since last result/clear) → `ACCUM` on first non-last term reaching stage 2; `ACCUM` → `IDLE` on last term reaching stage 2 or on clear. A last term arriving in `IDLE` produces a single-term result.
- Output: acc_valid cleared when acc_valid && acc_ready and no new result completes that cycle. New result completing while acc_valid && !acc_ready: acc_out overwritten, acc_valid stays 1, overrun ← 1. New result completing in the accept cycle: new value loaded, acc_valid stays 1, no overrun.
- No back-pressure to the multiplier; accumulation never stalls.
- clear and start_acc same cycle: clear wins, the product is dropped; in-flight stage-1 term is also dropped. clear does not touch acc_out/acc_valid.
- rst: all registers zero; in-flight terms dropped.

## Timing
- Reset values: acc_out 0, acc_valid 0, prod_cnt 0, overrun 0, sat_flag 0, FSM `IDLE`.
- Latency: start_acc sampled at edge N; aligned registered at N+1; acc / acc_out updated at N+2. acc_valid first visible after edge N+2.
- Throughput: one product per cycle, back-to-back start_acc fully supported, including a last term immediately followed by the first term of the next sum (goes into fresh acc = 0).
- prod_cnt reflects terms committed by stage 2 only.

## Configuration
- `FP_INT_ACC_SAT_EN` defined: stage-2 sum clamps to +2^(`ACC_WIDTH`−1)−1 or −2^(`ACC_WIDTH`−1) on signed overflow; sat_flag set sticky (cleared by rst/clear).
- Undefined: sum wraps modulo 2^`ACC_WIDTH`; sat_flag tied 0.

## Test plan
- Unit term: mantissa 1024, exp 15, sign 0, last 1 → acc_out 0x00000100 (1.0) at N+2, acc_valid 1, prod_cnt 0.
- Signed sum: terms (1024,15,+), (1024,16,−), (1536,15,+) last, one per cycle → acc_out 0x00000080 (0.5); mantissa 0, exp 28, sign 1 added → sum unchanged.
- Back-to-back sums: last on cycle k and new term on k+1 (1024,15,+) last → two results 1.0 each; second held until acc_ready; with acc_ready low, overrun = 1, acc_out = second result.
- Truncation: mantissa 1, exp 0, sign 1 → aligned 0, acc_out 0; mantissa 1024, exp 7 → 1.
- Saturation: 4000 consecutive terms (16383,31,+) then last → with `FP_INT_ACC_SAT_EN` acc_out 0x7FFFFFFF, sat_flag 1; without, wrapped value, sat_flag 0.
- clear/rst mid-sum: two terms in flight, clear asserted with a third start_acc → no result, prod_cnt 0; next single last term (1024,15,+) → exactly 1.0.
